// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences one load/store at a time between the MEM stage and a
// variable-latency word-wide data RAM.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/ctrl/addr/wdata  request from MEM stage (sampled only in idle)
//   req_ready, stall      handshake / pipeline freeze
//   rsp_valid/rdata/err   one-cycle completion pulse, extended load data, error flag
//   mem_en/we/addr/wdata  memory strobe, byte enables, word address, lane-replicated data
//   mem_rdy, mem_rdata    memory completion and read word
//
// ctrl codes: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH, 8..15 invalid.
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_t;

    state_t         state;
    logic [3:0]     ctrl_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    rdata_q;

    logic           fault;
    logic [7:0]     rbyte;
    logic [15:0]    rhalf;
    logic [31:0]    ld_data;

    // Alignment / code check on the live request, evaluated in the acceptance cycle.
    always_comb begin
        fault = 1'b0;
        unique case (req_ctrl)
            4'd0, 4'd5:       fault = |req_addr[1:0];
            4'd3, 4'd4, 4'd7: fault = req_addr[0];
            4'd1, 4'd2, 4'd6: fault = 1'b0;
            default:          fault = 1'b1;
        endcase
    end

    // Lane select and extension of the returned word.
    always_comb begin
        rbyte = 8'h00;
        case (addr_q[1:0])
            2'd0: rbyte = mem_rdata[7:0];
            2'd1: rbyte = mem_rdata[15:8];
            2'd2: rbyte = mem_rdata[23:16];
            default: rbyte = mem_rdata[31:24];
        endcase
        rhalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = 32'h0;
        case (ctrl_q)
            4'd0: ld_data = mem_rdata;
            4'd1: ld_data = {{24{rbyte[7]}}, rbyte};
            4'd2: ld_data = {24'h0, rbyte};
            4'd3: ld_data = {{16{rhalf[15]}}, rhalf};
            4'd4: ld_data = {16'h0, rhalf};
            default: ld_data = 32'h0;  // stores report zero data
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            ctrl_q  <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        ctrl_q  <= req_ctrl;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= '0;
                        if (fault) begin
                            rdata_q <= 32'h0;
                            state   <= StErr;
                        end else begin
                            state   <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    // A ready on the last allowed cycle still completes normally.
                    if (mem_rdy) begin
                        rdata_q <= ld_data;
                        state   <= StResp;
                    end else if (cnt_q == CntLast) begin
                        rdata_q <= 32'h0;
                        state   <= StErr;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Outputs decode the registered state, so the async reset clears them at once.
    always_comb begin
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        if (state == StAccess) begin
            case (ctrl_q)
                4'd5: begin
                    mem_we    = 4'b1111;
                    mem_wdata = wdata_q;
                end
                4'd6: begin
                    mem_we    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                4'd7: begin
                    mem_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_we    = 4'b0000;
                    mem_wdata = 32'h0;
                end
            endcase
        end
    end

    assign req_ready = (state == StIdle);
    assign stall     = (state == StAccess) || ((state == StIdle) && req_valid);
    assign mem_en    = (state == StAccess);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign rsp_valid = (state == StResp) || (state == StErr);
    assign rsp_err   = (state == StErr);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;
    logic [31:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request during one idle cycle; returns at the first ACCESS/ERR negedge.
    task automatic start(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_ctrl  = c;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0; req_ctrl = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_rdy = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, stall, rsp_valid, rsp_err, mem_en} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {req_ready, stall, rsp_valid, rsp_err, mem_en});
        end
        checks++;
        if ({mem_we, rsp_rdata, mem_addr, mem_wdata} !== 100'h0) begin
            fails++;
            $display("FAIL reset_data: got we=%b rd=%h ad=%h wd=%h want all zero",
                     mem_we, rsp_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_lb_sign;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = 4'd1; req_addr = 32'h13; req_wdata = 32'h0;
        mem_rdy = 1'b1; mem_rdata = 32'h80FF_1234;
        #1;
        checks++;
        if (stall !== 1'b1 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL lb_accept: got stall=%b mem_en=%b want 1 0", stall, mem_en);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({mem_en, stall, req_ready, mem_we} !== 7'b1100000 || mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL lb_access: got en=%b st=%b rdy=%b we=%b ad=%h want 1 1 0 0000 10",
                     mem_en, stall, req_ready, mem_we, mem_addr);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || stall !== 1'b0 || mem_en !== 1'b0
            || rsp_rdata !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_resp: got v=%b e=%b st=%b en=%b rd=%h want 1 0 0 0 ffffff80",
                     rsp_valid, rsp_err, stall, mem_en, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_hold: got v=%b rdy=%b rd=%h want 0 1 ffffff80",
                     rsp_valid, req_ready, rsp_rdata);
        end
    endtask

    // Counts ACCESS cycles; ready is raised on cycle rdy_at (0 = never).
    task automatic run_wait(input int rdy_at, input logic [31:0] rd, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (mem_en) begin
                n++;
                if (n == rdy_at) begin
                    mem_rdy = 1'b1;
                    mem_rdata = rd;
                end
            end else if (rsp_valid) begin
                break;
            end
        end
        mem_rdy = 1'b0;
    endtask

    task automatic test_lhu_zero;
        int n;
        mem_rdy = 1'b0;
        start(4'd4, 32'h22, 32'h0);
        run_wait(4, 32'hBEEF_0001, n);
        checks++;
        if (n !== 4) begin
            fails++;
            $display("FAIL lhu_cycles: got %0d want 4", n);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_BEEF) begin
            fails++;
            $display("FAIL lhu_resp: got v=%b e=%b rd=%h want 1 0 0000beef",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_store_lanes;
        logic [3:0]  c  [3] = '{4'd6, 4'd7, 4'd5};
        logic [31:0] a  [3] = '{32'h7, 32'h2, 32'h8};
        logic [31:0] d  [3] = '{32'h1234_56A5, 32'h0000_CAFE, 32'hDEAD_BEEF};
        logic [3:0]  we [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] wd [3] = '{32'hA5A5_A5A5, 32'hCAFE_CAFE, 32'hDEAD_BEEF};
        logic [31:0] ad [3] = '{32'h4, 32'h0, 32'h8};
        for (int k = 0; k < 3; k++) begin
            mem_rdy = 1'b0;
            start(c[k], a[k], d[k]);
            checks++;
            if (mem_en !== 1'b1 || mem_we !== we[k] || mem_wdata !== wd[k]
                || mem_addr !== ad[k]) begin
                fails++;
                $display("FAIL store%0d_lanes: got en=%b we=%b wd=%h ad=%h want 1 %b %h %h",
                         k, mem_en, mem_we, mem_wdata, mem_addr, we[k], wd[k], ad[k]);
            end
            mem_rdy = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            mem_rdy = 1'b0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0
                || mem_we !== 4'b0000) begin
                fails++;
                $display("FAIL store%0d_resp: got v=%b e=%b rd=%h we=%b want 1 0 0 0000",
                         k, rsp_valid, rsp_err, rsp_rdata, mem_we);
            end
        end
    endtask

    task automatic test_fault;
        logic [3:0]  c [3] = '{4'd5, 4'd9, 4'd3};
        logic [31:0] a [3] = '{32'h6, 32'h0, 32'h1};
        int seen;
        // Leave nonzero response data behind so zeroing on error is visible.
        mem_rdy = 1'b0;
        start(4'd0, 32'h30, 32'h0);
        mem_rdy = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            @(negedge clk);
            req_valid = 1'b1; req_ctrl = c[k]; req_addr = a[k];
            #1;
            if (mem_en) seen++;
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_en) seen++;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0
                || stall !== 1'b0) begin
                fails++;
                $display("FAIL fault%0d_resp: got v=%b e=%b rd=%h st=%b want 1 1 0 0",
                         k, rsp_valid, rsp_err, rsp_rdata, stall);
            end
            @(negedge clk);
            if (mem_en) seen++;
            checks++;
            if (seen !== 0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL fault%0d_after: got en_seen=%0d v=%b rdy=%b want 0 0 1",
                         k, seen, rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        mem_rdy = 1'b0;
        start(4'd0, 32'h40, 32'h0);
        run_wait(0, 32'h0, n);
        checks++;
        if (n !== 4 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL timeout_err: got n=%0d v=%b e=%b rd=%h want 4 1 1 0",
                     n, rsp_valid, rsp_err, rsp_rdata);
        end
        start(4'd0, 32'h44, 32'h0);
        run_wait(4, 32'h1357_9BDF, n);
        checks++;
        if (n !== 4 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1357_9BDF) begin
            fails++;
            $display("FAIL timeout_last_ok: got n=%0d v=%b e=%b rd=%h want 4 1 0 13579bdf",
                     n, rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        mem_rdy = 1'b0;
        start(4'd5, 32'h80, 32'h1111_2222);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'b1111) begin
            fails++;
            $display("FAIL rstmid_pre: got en=%b we=%b want 1 1111", mem_en, mem_we);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 4'b0000 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_drop: got en=%b we=%b rdy=%b want 0 0000 1",
                     mem_en, mem_we, req_ready);
        end
        mem_rdy = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rdy = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_idle: got v=%b rdy=%b rd=%h want 0 1 0",
                     rsp_valid, req_ready, rsp_rdata);
        end
        start(4'd0, 32'h84, 32'h0);
        mem_rdy = 1'b1; mem_rdata = 32'h0BAD_F00D;
        checks++;
        if (mem_addr !== 32'h84 || mem_we !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_lw_access: got ad=%h we=%b want 84 0000", mem_addr, mem_we);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
            fails++;
            $display("FAIL rstmid_lw_resp: got v=%b e=%b rd=%h want 1 0 0badf00d",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = 4'd2; req_addr = 32'h1; req_wdata = 32'h0;
        mem_rdy = 1'b1; mem_rdata = 32'h0000_AB00;
        @(negedge clk);
        // Request changes while busy must not disturb the access in flight.
        req_ctrl = 4'd5; req_addr = 32'h10; req_wdata = 32'h7777_8888;
        #1;
        checks++;
        if (mem_we !== 4'b0000 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL b2b_ignore: got we=%b ad=%h want 0000 0", mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (rsp_rdata !== 32'h0000_00AB || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_resp: got rd=%h rdy=%b v=%b want 000000ab 0 1",
                     rsp_rdata, req_ready, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b1 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: got rdy=%b st=%b en=%b want 1 1 0",
                     req_ready, stall, mem_en);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'b1111 || mem_addr !== 32'h10
            || mem_wdata !== 32'h7777_8888) begin
            fails++;
            $display("FAIL b2b_second: got en=%b we=%b ad=%h wd=%h want 1 1111 10 77778888",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL b2b_second_resp: got v=%b rd=%h want 1 0", rsp_valid, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_lhu_zero();
        test_store_lanes();
        test_fault();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer between the MEM pipeline stage and a variable-latency word-wide data RAM.
- Accepts one load/store request at a time and checks alignment.
- For stores, generates byte enables and lane-replicated write data; for loads, performs the byte/halfword select and sign/zero extension.
- Holds the pipeline stalled until the memory signals ready, and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 16, maximum number of cycles spent in ACCESS waiting for mem_rdy before an error response; legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- req_valid  input  1  MEM stage presents a request.
- req_ctrl  input  4  operation: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH; 8..15 invalid.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte or low half used for SB/SH.
- req_ready  output  1  high only in IDLE.
- stall  output  1  freeze request to pipeline.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load result; 0 for stores and errors.
- rsp_err  output  1  qualifies rsp_valid: misaligned, invalid code, or timeout.
- mem_en  output  1  memory access strobe.
- mem_we  output  4  byte write enables; bit i = byte lane i.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdy  input  1  memory completes access this cycle.
- mem_rdata  input  32  read word, valid when mem_rdy.

Behaviour:
- **States:** IDLE, ACCESS, RESP, ERR. Encoding is free.
- **Reset:** asynchronous. State=IDLE, latched regs=0, timeout counter=0. Outputs: req_ready=1; stall, rsp_valid, rsp_err, mem_en=0; mem_we=0; rsp_rdata, mem_addr, mem_wdata=0.
- **Reset mid-ACCESS:** mem_en and mem_we drop immediately, with no extra cycle. Any in-flight memory response is ignored.
- **IDLE:**
  - req_ready=1; stall=req_valid.
  - On req_valid, latch ctrl, addr and wdata at the clock edge.
  - Fault if: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; or ctrl>=8. A fault goes to ERR; otherwise go to ACCESS with counter cleared.
- **ACCESS:**
  - mem_en=1; stall=1; req_ready=0; mem_addr from the latched address.
  - mem_we encoding:
    - SW: 4'b1111.
    - SH: 4'b0011 when addr[1]=0, else 4'b1100.
    - SB: 4'b0001 shifted left by addr[1:0].
    - Loads: 4'b0000.
  - mem_wdata encoding:
    - SW: wdata.
    - SH: {2{wdata[15:0]}}.
    - SB: {4{wdata[7:0]}}.
    - Loads: 0.
  - mem_rdy=1: capture the extended result and go to RESP.
  - mem_rdy=0: counter increments. When counter==TIMEOUT-1 and mem_rdy=0, go to ERR.
  - mem_rdy=1 on the final allowed cycle completes normally; success wins over timeout.
- **Load extension:**
  - LB/LBU select byte addr[1:0] and sign- or zero-extend to 32 bits.
  - LH/LHU select half addr[1] and extend.
  - LW passes the word through.
- **RESP:** rsp_valid=1, rsp_err=0, stall=0, mem_en=0. Next state IDLE.
- **ERR:** rsp_valid=1, rsp_err=1, rsp_rdata=0, stall=0, mem_en=0. Next state IDLE.
- **rsp_rdata hold:** keeps its value until the next response.
- **Latency:** acceptance cycle → ACCESS (≥1 cycle) → RESP. With zero-wait memory, rsp_valid is asserted 2 cycles after the acceptance edge. A misaligned request responds 1 cycle after acceptance.
- **No back-to-back overlap:** a request held during RESP/ERR is accepted only once back in IDLE.
- **Ignored inputs:** mem_rdy outside ACCESS; req_* outside IDLE.
- **Counter width:** ceil(log2(TIMEOUT)); it must not wrap within a single access.

Test Plan:
- **LB sign extension:** LB addr=0x0000_0013, mem_rdy on first ACCESS cycle, mem_rdata=0x80FF_1234 → mem_we=0000, mem_addr=0x10; rsp_rdata=0xFFFF_FF80 two cycles after acceptance; stall high for acceptance+ACCESS cycles only.
- **LHU zero extension:** LHU addr=0x22, 3 wait cycles, mem_rdata=0xBEEF_0001 → mem_en held 4 cycles; rsp_rdata=0x0000_BEEF, rsp_err=0.
- **SB/SH lane placement:** SB addr=0x7, wdata=0x1234_56A5 → mem_we=1000, mem_wdata=0xA5A5_A5A5. SH addr=0x2, wdata=0xCAFE → mem_we=1100, mem_wdata=0xCAFE_CAFE.
- **Misalignment and invalid codes:** SW addr=0x6 → no mem_en ever; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0. Repeat with ctrl=9 → same response.
- **Timeout:** TIMEOUT=4, LW, mem_rdy stuck low → exactly 4 ACCESS cycles, then ERR pulse. Repeat with mem_rdy=1 on the 4th cycle → normal RESP, rsp_err=0.
- **Reset mid-access:** reset asserted mid-ACCESS between clock edges → mem_en=0 and req_ready=1 immediately. After release, a fresh LW completes normally with no leftover state.
